// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: sequences lw/sw/R-type/beq/addi/j through a Moore FSM
// and drives the datapath selects, write enables and a memory request/ready handshake.
module mips_mc_ctrl #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;
  logic   rdy;
  logic   bad_op;

  // Without wait support every access is assumed to complete in its first cycle.
  assign rdy = mem_ready | ~MEM_WAIT_EN;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    bad_op  = 1'b0;
    case (state_q)
      StFetch:  state_d = rdy ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default: begin
            state_d = StFetch;
            bad_op  = 1'b1;
          end
        endcase
      end
      StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = rdy ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = rdy ? StFetch : StMemWr;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJEx:     state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = rdy;
        pcen    = rdy;
      end
      StDecode: begin
        alusrcb = 2'b11;
        illegal = bad_op;
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StRtypeWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBeqEx: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb:  regwrite = 1'b1;
      StJEx: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // Block every side effect while reset is held, even before the state register settles.
    if (!reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-instruction expected cycle traces built from the instruction
// timing rules, replayed against the DUT with random ready stalls and random opcodes.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen, illegal;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
    logic       zero;
    outs_t      o;
  } ent_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op;
  logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal;
  logic [3:0] state_dbg;

  logic       nw_mem_req, nw_iord, nw_memwrite, nw_irwrite, nw_regdst, nw_memtoreg;
  logic       nw_regwrite, nw_alusrca, nw_pcen, nw_illegal;
  logic [1:0] nw_alusrcb, nw_aluop, nw_pcsrc;
  logic [3:0] nw_state_dbg;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) u_dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  // Single-cycle-memory variant: ready tied low, always running lw.
  mips_mc_ctrl #(.MEM_WAIT_EN(1'b0), .STATE_W(4)) u_nw (
    .clk(clk), .reset(reset), .op(OP_LW), .zero(1'b0), .mem_ready(1'b0),
    .mem_req(nw_mem_req), .iord(nw_iord), .memwrite(nw_memwrite), .irwrite(nw_irwrite),
    .regdst(nw_regdst), .memtoreg(nw_memtoreg), .regwrite(nw_regwrite),
    .alusrca(nw_alusrca), .alusrcb(nw_alusrcb), .aluop(nw_aluop), .pcsrc(nw_pcsrc),
    .pcen(nw_pcen), .illegal(nw_illegal), .state_dbg(nw_state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
         alusrcb, aluop, pcsrc, pcen, illegal};
    return o;
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] iop,
                      input logic z, input outs_t o);
    ent_t e;
    e.st = st; e.rdy = rdy; e.op = iop; e.zero = z; e.o = o;
    q.push_back(e);
  endtask

  // Expected trace of one instruction: fw fetch stalls, mw memory stalls.
  task automatic build(input logic [5:0] iop, input logic z, input int fw, input int mw);
    outs_t o;
    logic  known;
    known = iop inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    for (int i = 0; i <= fw; i++) begin
      o = '0; o.mem_req = 1'b1; o.alusrcb = 2'b01;
      o.irwrite = (i == fw); o.pcen = (i == fw);
      push(4'd0, i == fw, 6'($urandom), 1'($urandom), o);
    end
    o = '0; o.alusrcb = 2'b11; o.illegal = ~known;
    push(4'd1, 1'($urandom), iop, 1'($urandom), o);
    if (iop == OP_LW || iop == OP_SW) begin
      o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
      push(4'd2, 1'($urandom), iop, 1'($urandom), o);
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.memwrite = (iop == OP_SW);
        push((iop == OP_LW) ? 4'd3 : 4'd5, i == mw, iop, 1'($urandom), o);
      end
      if (iop == OP_LW) begin
        o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1;
        push(4'd4, 1'($urandom), iop, 1'($urandom), o);
      end
    end else if (iop == OP_R) begin
      o = '0; o.alusrca = 1'b1; o.aluop = 2'b10;
      push(4'd6, 1'($urandom), iop, 1'($urandom), o);
      o = '0; o.regdst = 1'b1; o.regwrite = 1'b1;
      push(4'd7, 1'($urandom), iop, 1'($urandom), o);
    end else if (iop == OP_BEQ) begin
      o = '0; o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z;
      push(4'd8, 1'($urandom), iop, z, o);
    end else if (iop == OP_ADDI) begin
      o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
      push(4'd9, 1'($urandom), iop, 1'($urandom), o);
      o = '0; o.regwrite = 1'b1;
      push(4'd10, 1'($urandom), iop, 1'($urandom), o);
    end else if (iop == OP_J) begin
      o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1;
      push(4'd11, 1'($urandom), iop, 1'($urandom), o);
    end
  endtask

  // Replays up to n queued cycles; called right after an active edge.
  task automatic play(input int n);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      op = e.op; zero = e.zero; mem_ready = e.rdy;
      @(negedge clk);
      chk($sformatf("state op=%b", e.op), 32'(state_dbg), 32'(e.st));
      chk($sformatf("outs st=%0d", e.st), 32'(dut_outs()), 32'(e.o));
      chk("aluop_not_11", 32'(aluop == 2'b11), 32'd0);
      chk("memwrite_and_regwrite", 32'(memwrite & regwrite), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] iop, input logic z, input int fw, input int mw);
    build(iop, z, fw, mw);
    play(q.size());
  endtask

  task automatic do_reset();
    outs_t o;
    reset = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = '0; o.alusrcb = 2'b01;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_outs", 32'(dut_outs()), 32'(o));
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] iop;
    logic [3:0] nw_seq[6];
    nw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    reset = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    run_instr(OP_LW, 1'b0, 0, 0);
    run_instr(OP_SW, 1'b0, 0, 3);
    run_instr(OP_R, 1'b0, 1, 0);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_J, 1'b0, 2, 0);
    run_instr(6'b111111, 1'b0, 0, 0);

    // Reset asserted in the middle of RTYPEWB.
    build(OP_R, 1'b0, 0, 0);
    play(3);
    q.delete();
    op = OP_R; mem_ready = 1'b0;
    @(negedge clk);
    chk("rtypewb_state", 32'(state_dbg), 32'd7);
    chk("rtypewb_regwrite", 32'(regwrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_state", 32'(state_dbg), 32'd0);
    chk("async_reset_regwrite", 32'(regwrite), 32'd0);
    chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_irwrite", 32'(irwrite), 32'd0);
    @(posedge clk); #1;
    chk("reset_hold_state", 32'(state_dbg), 32'd0);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("release_irwrite", 32'(irwrite), 32'd1);
    chk("release_pcen", 32'(pcen), 32'd1);
    do_reset();

    repeat (150) begin
      case ($urandom_range(0, 6))
        0: iop = OP_LW;
        1: iop = OP_SW;
        2: iop = OP_R;
        3: iop = OP_BEQ;
        4: iop = OP_ADDI;
        5: iop = OP_J;
        default: begin
          do iop = 6'($urandom);
          while (iop inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
        end
      endcase
      run_instr(iop, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Ready ignored when wait support is off: lw runs in 5 cycles.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("nowait_lw_state%0d", k), 32'(nw_state_dbg), 32'(nw_seq[k]));
      if (k == 0) chk("nowait_irwrite", 32'(nw_irwrite), 32'd1);
      if (k == 4) chk("nowait_regwrite", 32'(nw_regwrite), 32'd1);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle MIPS main controller FSM. It issues the 2-bit aluop code consumed by the existing ALU-function decoder, which maps it together with funct to the 3-bit alucontrol. It also drives all datapath mux selects and write enables for lw, sw, R-type, beq, addi and j. Memory accesses use a request/ready handshake so the datapath can sit behind a variable-latency memory.

Parameters:
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1 (single-cycle memory)
STATE_W, 4, width of state register and state_dbg port

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  6  instr[31:26] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current access this cycle
mem_req  output  1  memory access in progress (FETCH, MEMRD, MEMWR)
iord  output  1  0 = address from PC, 1 = from ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  1 = rd, 0 = rt
memtoreg  output  1  1 = writeback from data register
regwrite  output  1  register file write
alusrca  output  1  0 = PC, 1 = rs
alusrcb  output  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
aluop  output  2  00 add, 01 sub, 10 use funct (to ALU decoder)
pcsrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target
pcen  output  1  PC load = pcwrite | (branch & zero)
illegal  output  1  one-cycle pulse: unsupported opcode decoded
state_dbg  output  STATE_W  current state encoding

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12-15 go to FETCH on the next edge.
- Reset: while reset = 0, state = FETCH asynchronously, and pcen, irwrite, regwrite, memwrite, mem_req and illegal are forced to 0. Other outputs take their FETCH values. Reset mid-instruction abandons it; no partial write occurs after reset is asserted.
- Outputs are Moore-decoded from state, except irwrite/pcen in FETCH, which are gated by the effective ready (rdy = mem_ready | ~MEM_WAIT_EN). Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcen=rdy. Go to DECODE when rdy, else stay.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - lw 100011 / sw 101011 -> MEMADR
  - R-type 000000 -> RTYPEEX
  - beq 000100 -> BEQEX
  - addi 001000 -> ADDIEX
  - j 000010 -> JEX
  - any other op -> FETCH, with illegal=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD if op=lw, else MEMWR.
- MEMRD: mem_req=1, iord=1. Stay until rdy, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1 held every cycle until rdy, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10, then RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JEX: pcsrc=10, pcen=1, then FETCH.
- aluop is never 11. memwrite and regwrite are never high in the same cycle.
- Cycle counts with rdy always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each extra rdy=0 cycle in a memory state adds 1.
- op is sampled only in DECODE and MEMADR; the datapath holds op stable via the instruction register.

Test Plan:
- Reset: reset=0 mid-RTYPEWB -> state_dbg=0 immediately, regwrite=0, mem_req=0; release with mem_ready=1 -> irwrite=pcen=1 in first cycle.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; MEMWB has regwrite=1, memtoreg=1, regdst=0; 5 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH; regwrite stays 0.
- R-type (op=000000) -> RTYPEEX aluop=10, alusrcb=00; RTYPEWB regdst=1, regwrite=1.
- beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0; both return to FETCH.
- op=111111 in DECODE -> illegal=1 for one cycle, next state FETCH, no register or memory write. Also run MEM_WAIT_EN=0 with mem_ready=0: lw completes in 5 cycles.
